// File: rtl/parking_gate_sequencer.sv
// Initiator-side driver for the parking_system barrier: turns a one-cycle car
// arrival request into entrance/password/exit stimulus and reports the outcome.
module parking_gate_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned GREEN_CONFIRM  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned RETRY_GAP      = 8,
  parameter int unsigned EXIT_CYCLES    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pw1_in,
  input  logic [1:0] pw2_in,
  input  logic       GREEN_LED,
  input  logic       RED_LED,
  output logic       sensor_entrance,
  output logic       sensor_exit,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic       busy,
  output logic       granted,
  output logic       denied,
  output logic [1:0] attempts
);

  localparam int unsigned PH_MAX0 = (SETTLE_CYCLES > RETRY_GAP) ? SETTLE_CYCLES : RETRY_GAP;
  localparam int unsigned PH_MAX  = (PH_MAX0 > EXIT_CYCLES) ? PH_MAX0 : EXIT_CYCLES;
  localparam int unsigned PH_W    = $clog2(PH_MAX) + 1;
  localparam int unsigned CF_W    = $clog2(GREEN_CONFIRM) + 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE, ARRIVE, PRESENT, GAP, PASS, DONE, FAIL
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase_cnt;
  logic [CF_W-1:0] confirm_cnt;
  logic [TO_W-1:0] timeout_cnt;
  logic [1:0]      pw1_q;
  logic [1:0]      pw2_q;

  logic            green_s;
  logic [CF_W-1:0] confirm_nxt;
  logic [TO_W-1:0] timeout_nxt;
  logic            enter_present;

  // RED_LED is monitored only and never alters the grant decision.
  assign green_s       = GREEN_LED & (RED_LED | ~RED_LED);
  assign confirm_nxt   = green_s ? (confirm_cnt + CF_W'(1)) : '0;
  assign timeout_nxt   = timeout_cnt + TO_W'(1);
  assign enter_present = ((state == ARRIVE) && (phase_cnt == PH_W'(SETTLE_CYCLES - 1))) ||
                         ((state == GAP)    && (phase_cnt == PH_W'(RETRY_GAP - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      phase_cnt       <= '0;
      confirm_cnt     <= '0;
      timeout_cnt     <= '0;
      pw1_q           <= 2'b00;
      pw2_q           <= 2'b00;
      sensor_entrance <= 1'b0;
      sensor_exit     <= 1'b0;
      password_1      <= 2'b00;
      password_2      <= 2'b00;
      busy            <= 1'b0;
      granted         <= 1'b0;
      denied          <= 1'b0;
      attempts        <= 2'b00;
    end else begin
      granted <= 1'b0;
      denied  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pw1_q           <= pw1_in;
            pw2_q           <= pw2_in;
            attempts        <= 2'b00;
            phase_cnt       <= '0;
            sensor_entrance <= 1'b1;
            busy            <= 1'b1;
            state           <= ARRIVE;
          end
        end
        ARRIVE, GAP: phase_cnt <= phase_cnt + PH_W'(1);
        PRESENT: begin
          // A completed green run wins over a coincident timeout.
          if (confirm_nxt == CF_W'(GREEN_CONFIRM)) begin
            sensor_entrance <= 1'b0;
            sensor_exit     <= 1'b1;
            password_1      <= 2'b00;
            password_2      <= 2'b00;
            phase_cnt       <= '0;
            state           <= PASS;
          end else if (timeout_nxt == TO_W'(TIMEOUT_CYCLES)) begin
            password_1 <= 2'b00;
            password_2 <= 2'b00;
            phase_cnt  <= '0;
            if (32'(attempts) <= MAX_RETRY) begin
              state <= GAP;
            end else begin
              sensor_entrance <= 1'b0;
              denied          <= 1'b1;
              state           <= FAIL;
            end
          end else begin
            confirm_cnt <= confirm_nxt;
            timeout_cnt <= timeout_nxt;
          end
        end
        PASS: begin
          if (phase_cnt == PH_W'(EXIT_CYCLES - 1)) begin
            sensor_exit <= 1'b0;
            granted     <= 1'b1;
            state       <= DONE;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        DONE, FAIL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Shared entry into a password window from ARRIVE or GAP.
      if (enter_present) begin
        password_1  <= pw1_q;
        password_2  <= pw2_q;
        attempts    <= (attempts == 2'b11) ? 2'b11 : (attempts + 2'b01);
        confirm_cnt <= '0;
        timeout_cnt <= '0;
        phase_cnt   <= '0;
        state       <= PRESENT;
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Bench for parking_gate_sequencer: a timeline model derived from the green
// schedule predicts every output per cycle; literal pins anchor the model.
module tb_parking_gate_sequencer;

  localparam int SETTLE  = 4;
  localparam int CONFIRM = 3;
  localparam int TMO     = 64;
  localparam int RETRY   = 2;
  localparam int GAPC    = 8;
  localparam int EXITC   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] pw1_in = 2'b00;
  logic [1:0] pw2_in = 2'b00;
  logic       GREEN_LED = 1'b0;
  logic       RED_LED = 1'b0;
  logic       sensor_entrance, sensor_exit, busy, granted, denied;
  logic [1:0] password_1, password_2, attempts;

  parking_gate_sequencer #(
    .SETTLE_CYCLES(SETTLE), .GREEN_CONFIRM(CONFIRM), .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY(RETRY), .RETRY_GAP(GAPC), .EXIT_CYCLES(EXITC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pw1_in(pw1_in), .pw2_in(pw2_in),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .password_1(password_1), .password_2(password_2), .busy(busy),
    .granted(granted), .denied(denied), .attempts(attempts)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  bit         gvec [0:511];
  int         win_s [0:2];
  int         n_win, pass_j, fail_j;
  logic [1:0] m_pw1, m_pw2;
  bit         active = 1'b0;
  int         jj = 0;
  int         tid = 0;
  logic [10:0] cmp_e, cmp_a;

  // Outcome of one car from the green schedule: window starts, pass or fail cycle.
  function automatic void plan();
    int run;
    int s;
    pass_j = -1;
    fail_j = -1;
    n_win  = 0;
    for (int w = 0; w <= RETRY && pass_j < 0; w++) begin
      s = SETTLE + w * (TMO + GAPC);
      win_s[w] = s;
      n_win = w + 1;
      run = 0;
      for (int p = 0; p < TMO && pass_j < 0; p++) begin
        run = gvec[s + p] ? run + 1 : 0;
        if (run == CONFIRM) pass_j = s + p + 1;
      end
    end
    if (pass_j < 0) fail_j = win_s[RETRY] + TMO;
  endfunction

  function automatic logic [10:0] model_out(input int j);
    int         end_j, att;
    logic       e_en, e_ex, e_bz, e_gr, e_dn;
    logic [1:0] p1, p2;
    end_j = (pass_j >= 0) ? pass_j : fail_j;
    e_en = (j < end_j);
    p1 = 2'b00;
    p2 = 2'b00;
    att = 0;
    for (int w = 0; w < n_win; w++) begin
      if (j >= win_s[w]) att++;
      if (j >= win_s[w] && j < win_s[w] + TMO && j < end_j) begin
        p1 = m_pw1;
        p2 = m_pw2;
      end
    end
    e_ex = (pass_j >= 0) && (j >= pass_j) && (j < pass_j + EXITC);
    e_gr = (pass_j >= 0) && (j == pass_j + EXITC);
    e_dn = (fail_j >= 0) && (j == fail_j);
    e_bz = (j <= ((pass_j >= 0) ? pass_j + EXITC : fail_j));
    return {e_en, e_ex, p1, p2, e_bz, e_gr, e_dn, 2'(att)};
  endfunction

  always @(negedge clk) begin
    if (active) begin
      cmp_e = model_out(jj);
      cmp_a = {sensor_entrance, sensor_exit, password_1, password_2, busy, granted, denied, attempts};
      checks++;
      if (cmp_a !== cmp_e) begin
        failures++;
        $display("FAIL cycle_t%0d_j%0d act=%b exp=%b (en,ex,pw1,pw2,busy,gr,dn,att)", tid, jj, cmp_a, cmp_e);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic lit(input int t, input int j);
    if (t == 1) begin
      case (j)
        0:  chk("t1_entr_rise", int'(sensor_entrance), 1);
        3:  chk("t1_pw_before", int'(password_1), 0);
        4:  begin chk("t1_pw1", int'(password_1), 1); chk("t1_pw2", int'(password_2), 2); end
        17: begin chk("t1_exit_on", int'(sensor_exit), 1); chk("t1_entr_off", int'(sensor_entrance), 0); end
        21: chk("t1_exit_last", int'(sensor_exit), 1);
        22: begin chk("t1_granted", int'(granted), 1); chk("t1_exit_off", int'(sensor_exit), 0);
                  chk("t1_att", int'(attempts), 1); end
        23: begin chk("t1_idle", int'(busy), 0); chk("t1_no_restart", int'(sensor_entrance), 0); end
        default: ;
      endcase
    end else if (t == 2) begin
      case (j)
        67:  chk("t2_pw_last", int'(password_1), 3);
        68:  begin chk("t2_gap_pw", int'(password_1), 0); chk("t2_gap_entr", int'(sensor_entrance), 1);
                   chk("t2_att1", int'(attempts), 1); end
        76:  begin chk("t2_pw_retry", int'(password_1), 3); chk("t2_att2", int'(attempts), 2); end
        148: chk("t2_att3", int'(attempts), 3);
        212: begin chk("t2_denied", int'(denied), 1); chk("t2_entr_off", int'(sensor_entrance), 0);
                   chk("t2_no_grant", int'(granted), 0); end
        213: begin chk("t2_idle", int'(busy), 0); chk("t2_att_hold", int'(attempts), 3); end
        default: ;
      endcase
    end else if (t == 3) begin
      case (j)
        11: begin chk("t3_no_pass_2run", int'(sensor_exit), 0); chk("t3_still_pw", int'(password_1), 2); end
        14: chk("t3_exit_pending", int'(sensor_exit), 0);
        15: chk("t3_exit_on", int'(sensor_exit), 1);
        20: chk("t3_granted", int'(granted), 1);
        default: ;
      endcase
    end else if (t == 4) begin
      case (j)
        83: chk("t4_exit_pending", int'(sensor_exit), 0);
        84: chk("t4_exit_on", int'(sensor_exit), 1);
        89: begin chk("t4_granted", int'(granted), 1); chk("t4_att", int'(attempts), 2); end
        default: ;
      endcase
    end
  endtask

  task automatic clear_g();
    for (int i = 0; i < 512; i++) gvec[i] = 1'b0;
  endtask

  // One car: start, then drive the green schedule and stray starts per cycle.
  task automatic run_car(input int t, input logic [1:0] p1, input logic [1:0] p2,
                         input int poke_a, input int poke_b, input int stop_at);
    int last;
    tid = t;
    m_pw1 = p1;
    m_pw2 = p2;
    plan();
    last = ((pass_j >= 0) ? pass_j + EXITC : fail_j) + 3;
    if (stop_at >= 0) last = stop_at;
    @(posedge clk); #1;
    start = 1'b1; pw1_in = p1; pw2_in = p2; GREEN_LED = 1'b0;
    for (int j = 0; j <= last; j++) begin
      @(posedge clk); #1;
      jj = j;
      active = 1'b1;
      start = (j == poke_a) || (j == poke_b);
      pw1_in = start ? ~p1 : p1;
      pw2_in = start ? ~p2 : p2;
      GREEN_LED = gvec[j];
      @(negedge clk); #1;
      lit(t, j);
    end
    active = 1'b0;
    start = 1'b0;
    GREEN_LED = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", int'({sensor_entrance, sensor_exit, password_1, password_2, busy, granted, denied, attempts}), 0);
    reset = 1'b0;

    // Happy path; stray starts in PRESENT and in the DONE cycle.
    clear_g();
    for (int i = 14; i < 20; i++) gvec[i] = 1'b1;
    run_car(1, 2'b01, 2'b10, 8, 22, -1);

    // Green never seen: three windows then denied; stray starts in GAP and FAIL.
    clear_g();
    run_car(2, 2'b11, 2'b00, 70, 212, -1);

    // Two-cycle glitch then a full three-cycle run.
    clear_g();
    gvec[9] = 1'b1; gvec[10] = 1'b1;
    gvec[12] = 1'b1; gvec[13] = 1'b1; gvec[14] = 1'b1;
    run_car(3, 2'b10, 2'b11, -1, -1, -1);

    // Green in ARRIVE (spilling into PRESENT) and in GAP is ignored; grant in window two.
    clear_g();
    for (int i = 2; i <= 5; i++) gvec[i] = 1'b1;
    for (int i = 69; i <= 73; i++) gvec[i] = 1'b1;
    for (int i = 81; i <= 83; i++) gvec[i] = 1'b1;
    run_car(4, 2'b10, 2'b01, 30, 89, -1);

    // Asynchronous reset while sensor_exit is high, then a normal car.
    clear_g();
    for (int i = 14; i < 20; i++) gvec[i] = 1'b1;
    run_car(5, 2'b01, 2'b10, -1, -1, 19);
    chk("pre_rst_exit", int'(sensor_exit), 1);
    reset = 1'b1;
    #1;
    chk("rst_exit_drop", int'(sensor_exit), 0);
    chk("rst_entr_drop", int'(sensor_entrance), 0);
    chk("rst_busy_drop", int'(busy), 0);
    chk("rst_all_outs", int'({sensor_entrance, sensor_exit, password_1, password_2, busy, granted, denied, attempts}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_car(1, 2'b01, 2'b10, 8, 22, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
